// File: rtl/alpha_trim_ctrl_pkg.sv
// Shared definitions for the alpha-trimmed mean sequencer: state encoding, default
// geometry and the derivation of the kept-sample count and its fixed-point reciprocal.
package alpha_trim_ctrl_pkg;

  localparam int unsigned DN_DEF   = 25;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned TRIM_DEF = 4;
  localparam int unsigned TMO_DEF  = 64;

  typedef enum logic [6:0] {
    StIdle   = 7'b0000001,
    StLaunch = 7'b0000010,
    StWait   = 7'b0000100,
    StSettle = 7'b0001000,
    StAccum  = 7'b0010000,
    StDiv    = 7'b0100000,
    StOut    = 7'b1000000
  } state_e;

  function automatic int unsigned calc_k(input int unsigned dn, input int unsigned trim);
    return dn - 2 * trim;
  endfunction

  // round(2^16 / k)
  function automatic int unsigned calc_recip(input int unsigned k);
    return ((32'd1 << 16) + k / 2) / k;
  endfunction

  function automatic bit dn_trim_legal(input int unsigned dn, input int unsigned trim);
    return (2 * trim) < dn;
  endfunction

endpackage

// File: rtl/alpha_trim_ctrl_if.sv
// Window-in / mean-out stream bundle between a producer/consumer and the trim controller.
interface alpha_trim_ctrl_if
  import alpha_trim_ctrl_pkg::*;
#(
  parameter int unsigned DN = DN_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic             win_valid;
  logic             win_ready;
  logic [DW*DN-1:0] win_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_mean;

  modport master (
    output win_valid,
    output win_data,
    output out_ready,
    input  win_ready,
    input  out_valid,
    input  out_mean
  );

  modport slave (
    input  win_valid,
    input  win_data,
    input  out_ready,
    output win_ready,
    output out_valid,
    output out_mean
  );

endinterface

// File: rtl/alpha_recip_div.sv
// Divide-by-K stage: registers (sum * RECIP + 2^15) >> 16, i.e. the rounded mean.
module alpha_recip_div #(
  parameter int unsigned DW    = 8,
  parameter int unsigned SUMW  = 13,
  parameter int unsigned RECIP = 3855
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SUMW-1:0] sum,
  output logic [DW-1:0]   mean
);

  localparam int unsigned PW = SUMW + 16;

  logic [PW-1:0]   prod_d;
  logic [SUMW-1:0] prod_hi;
  logic [SUMW-1:0] prod_hi_q;

  assign prod_d  = PW'(sum) * PW'(RECIP) + PW'(32'd1 << 15);
  assign prod_hi = SUMW'(prod_d >> 16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_hi_q <= '0;
    end else if (load) begin
      prod_hi_q <= prod_hi;
    end
  end

  // Cannot exceed the pixel range for a valid RECIP; clamp rather than wrap regardless.
  assign mean = (|prod_hi_q[SUMW-1:DW]) ? '1 : prod_hi_q[DW-1:0];

endmodule

// File: rtl/alpha_trim_ctrl.sv
// Sequencer for the rank-sort engine: captures a window, fires the sort, sums the kept
// ranks through the returned index vector and hands back the rounded trimmed mean.
module alpha_trim_ctrl
  import alpha_trim_ctrl_pkg::*;
#(
  parameter int unsigned DN    = DN_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned IW    = $clog2(DN),
  parameter int unsigned TRIM  = TRIM_DEF,
  parameter int unsigned RECIP = calc_recip(calc_k(DN, TRIM)),
  parameter int unsigned TMO   = TMO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  alpha_trim_ctrl_if.slave bus,
  output logic             sort_start,
  output logic [DW*DN-1:0] sort_data,
  input  logic             sort_done,
  input  logic [IW*DN-1:0] sort_seq,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned K    = calc_k(DN, TRIM);
  localparam int unsigned SUMW = DW + $clog2(K + 1);
  localparam int unsigned WDW  = $clog2(TMO);

  localparam logic [IW-1:0]  PtrFirst = IW'(TRIM);
  localparam logic [IW-1:0]  PtrLast  = IW'(DN - TRIM - 1);
  localparam logic [WDW-1:0] WdogLast = WDW'(TMO - 1);

  if (!dn_trim_legal(DN, TRIM)) begin : g_bad_cfg
    $error("alpha_trim_ctrl: 2*TRIM must be smaller than DN");
  end

  state_e           state_q;
  logic [DW*DN-1:0] win_reg_q;
  logic [SUMW-1:0]  sum_q;
  logic [IW-1:0]    ptr_q;
  logic [WDW-1:0]   wdog_q;
  logic             win_ready_q;
  logic             sort_start_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             timeout_err_q;

  logic [DW-1:0] win_pix [DN];
  logic [IW-1:0] seq_idx [DN];
  logic [DW-1:0] sel_pix;
  logic [DW-1:0] div_mean;
  logic          div_load;

  for (genvar i = 0; i < DN; i++) begin : g_unpack
    assign win_pix[i] = win_reg_q[i*DW +: DW];
    assign seq_idx[i] = sort_seq[i*IW +: IW];
  end

  // Pixel holding rank ptr_q.
  assign sel_pix  = win_pix[seq_idx[ptr_q]];
  assign div_load = (state_q == StDiv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      win_reg_q     <= '0;
      sum_q         <= '0;
      ptr_q         <= '0;
      wdog_q        <= '0;
      win_ready_q   <= 1'b0;
      sort_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sort_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          win_ready_q <= 1'b1;
          if (bus.win_valid && win_ready_q) begin
            win_reg_q    <= bus.win_data;
            win_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            sort_start_q <= 1'b1;
            state_q      <= StLaunch;
          end
        end
        StLaunch: begin
          wdog_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (sort_done) begin
            state_q <= StSettle;
          end else if (wdog_q == WdogLast) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            win_ready_q   <= 1'b1;
            state_q       <= StIdle;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StSettle: begin
          ptr_q   <= PtrFirst;
          sum_q   <= '0;
          state_q <= StAccum;
        end
        StAccum: begin
          sum_q <= sum_q + SUMW'(sel_pix);
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == PtrLast) begin
            state_q <= StDiv;
          end
        end
        StDiv: begin
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            win_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  alpha_recip_div #(
    .DW    (DW),
    .SUMW  (SUMW),
    .RECIP (RECIP)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (div_load),
    .sum   (sum_q),
    .mean  (div_mean)
  );

  assign bus.win_ready = win_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mean  = div_mean;
  assign sort_start    = sort_start_q;
  assign sort_data     = win_reg_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_alpha_trim_ctrl.sv
// Scoreboard bench for alpha_trim_ctrl: a sort-engine model answers each start, and a
// monitor pops model-computed trimmed means as results are accepted.
module tb_alpha_trim_ctrl;

  localparam int DN   = 25;
  localparam int DW   = 8;
  localparam int IW   = 5;
  localparam int TRIM = 4;
  localparam int KEEP = DN - 2 * TRIM;
  localparam int RCP  = int'(65536.0 / KEEP);

  logic clk;
  logic rst_n;
  logic sort_start;
  logic [DW*DN-1:0] sort_data;
  logic sort_done;
  logic [IW*DN-1:0] sort_seq;
  logic busy;
  logic timeout_err;

  alpha_trim_ctrl_if #(.DN(DN), .DW(DW)) bus ();

  alpha_trim_ctrl #(
    .DN   (DN),
    .DW   (DW),
    .IW   (IW),
    .TRIM (TRIM),
    .TMO  (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sort_start  (sort_start),
    .sort_data   (sort_data),
    .sort_done   (sort_done),
    .sort_seq    (sort_seq),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int starts = 0;
  int windows = 0;
  int tmo_cnt = 0;
  int lat = 3;
  bit hang = 0;
  bit rand_rdy = 0;
  logic rdy_force = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Trimmed mean straight from the definition: sort, keep the middle ranks, scale.
  function automatic int model_mean(input int px[DN]);
    int s[DN];
    int t;
    int sum;
    s = px;
    for (int i = 0; i < DN; i++)
      for (int j = 0; j < DN - 1 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    sum = 0;
    for (int r = TRIM; r < DN - TRIM; r++) sum += s[r];
    return (sum * RCP + 32768) >> 16;
  endfunction

  task automatic send(input int px[DN], input bit expect_out);
    int n = 0;
    @(negedge clk);
    while (bus.win_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (bus.win_ready !== 1'b1) begin
      check("win_ready_wait", {31'd0, bus.win_ready}, 1);
      return;
    end
    for (int i = 0; i < DN; i++) bus.win_data[i*DW +: DW] = 8'(px[i]);
    bus.win_valid = 1'b1;
    windows++;
    if (expect_out) exp_q.push_back(model_mean(px));
    @(posedge clk);
    #1 bus.win_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_out_valid", {31'd0, bus.out_valid}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_win_ready"}, {31'd0, bus.win_ready}, 0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 0);
    check({tag, "_out_mean"}, {24'd0, bus.out_mean}, 0);
    check({tag, "_sort_start"}, {31'd0, sort_start}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 0);
    check({tag, "_sort_data"}, {31'd0, |sort_data}, 0);
  endtask

  // out_ready driver: random backpressure or a fixed level.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Sort-engine model: ascending ranks, ties kept in index order.
  initial begin : engine
    int v[DN];
    int ord[DN];
    int t;
    sort_done = 1'b0;
    sort_seq  = '0;
    forever begin
      @(negedge clk);
      if (sort_start === 1'b1 && !hang) begin
        for (int i = 0; i < DN; i++) begin
          v[i]   = int'(sort_data[i*DW +: DW]);
          ord[i] = i;
        end
        for (int i = 1; i < DN; i++)
          for (int j = i; j > 0 && v[ord[j-1]] > v[ord[j]]; j--) begin
            t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
          end
        repeat (lat) @(posedge clk);
        #1;
        sort_done = 1'b1;
        for (int r = 0; r < DN; r++) sort_seq[r*IW +: IW] = ord[r][IW-1:0];
        @(posedge clk);
        #1 sort_done = 1'b0;
      end
    end
  end

  initial begin : monitor
    bit pv;
    logic [7:0] hold;
    int e;
    pv = 0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pv = 0;
        continue;
      end
      if (sort_start === 1'b1) begin
        starts++;
        start_cyc = cyc;
      end
      if (sort_done === 1'b1) done_cyc = cyc;
      if (timeout_err === 1'b1) tmo_cnt++;
      if (bus.out_valid === 1'b1 && !pv) begin
        check("latency", cyc - done_cyc, KEEP + 3);
        hold = bus.out_mean;
      end else if (bus.out_valid === 1'b1) begin
        check("mean_stable", {24'd0, bus.out_mean}, {24'd0, hold});
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got mean %0d want no output", bus.out_mean);
        end else begin
          e = exp_q.pop_front();
          check("mean", {24'd0, bus.out_mean}, e);
        end
      end
      pv = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench stalled");
  end

  initial begin : main
    int px[DN];
    int j;
    int t;
    int n;
    bus.win_valid = 1'b0;
    bus.win_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Flat window.
    for (int i = 0; i < DN; i++) px[i] = 100;
    send(px, 1);
    drain();

    // Ramp: ranks 4..20 sum to 204.
    for (int i = 0; i < DN; i++) px[i] = i;
    send(px, 1);
    drain();

    // Extremes scattered among a flat body.
    for (int i = 0; i < DN; i++) px[i] = (i < 17) ? 50 : ((i < 21) ? 0 : 255);
    for (int i = DN - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = px[i]; px[i] = px[j]; px[j] = t;
    end
    send(px, 1);
    drain();

    // Backpressure in OUT, with a competing window offered.
    rdy_force = 1'b0;
    for (int i = 0; i < DN; i++) px[i] = $urandom_range(0, 255);
    send(px, 1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", {31'd0, bus.out_valid}, 1);
    bus.win_data  = '1;
    bus.win_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_win_ready", {31'd0, bus.win_ready}, 0);
      check("bp_out_valid", {31'd0, bus.out_valid}, 1);
    end
    bus.win_valid = 1'b0;
    rdy_force = 1'b1;
    drain();

    // Engine never answers: watchdog.
    hang = 1;
    for (int i = 0; i < DN; i++) px[i] = 9;
    send(px, 0);
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_seen", {31'd0, timeout_err}, 1);
    check("tmo_delay", cyc - start_cyc, 65);
    @(negedge clk);
    check("tmo_pulse", {31'd0, timeout_err}, 0);
    check("tmo_win_ready", {31'd0, bus.win_ready}, 1);
    check("tmo_no_out", {31'd0, bus.out_valid}, 0);
    hang = 0;
    for (int i = 0; i < DN; i++) px[i] = $urandom_range(0, 255);
    send(px, 1);
    drain();

    // Reset while accumulating.
    for (int i = 0; i < DN; i++) px[i] = 200;
    send(px, 1);
    n = 0;
    while (sort_done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 check_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DN; i++) px[i] = 7;
    send(px, 1);
    drain();

    // Random windows, engine latencies and backpressure.
    rand_rdy = 1;
    for (int w = 0; w < 20; w++) begin
      lat = $urandom_range(1, 6);
      for (int i = 0; i < DN; i++) px[i] = $urandom_range(0, 255);
      send(px, 1);
    end
    drain();
    rand_rdy = 0;

    check("start_count", starts, windows);
    check("tmo_count", tmo_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
